// File: rtl/legv8_mem_controller.sv
// ---------------------------------------------------------------------------
// legv8_mem_controller
//
// Purpose: sequences single LDUR/STUR accesses from a LEGv8 pipeline onto a
// synchronous 64-bit data RAM. The request/response handshake uses
// valid/ready. Every access takes the path IDLE -> WRITE|READ -> RESP -> IDLE,
// so one access completes every 3 cycles when the response is always consumed.
//
// Optional feature (macro MEM_BOUNDS_CHECK_EN):
//   defined   - misaligned, out-of-range (word >= MEMORY_WORDS) and high-address
//               (req_addr[63:16] != 0) requests skip the RAM entirely and
//               answer with rsp_error = 1.
//   undefined - no checking. The word address is req_addr[15:3] and
//               rsp_error is always 0.
//
// Ports:
//   clock, reset_n          single clock; async active-low reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_store               1 = store (STUR), 0 = load (LDUR)
//   req_addr, req_wdata     byte address, store data
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata, rsp_error    load data (0 for stores/errors), fault flag
//   mem_address, mem_in     RAM word address and write data
//   mem_write               RAM write enable (high for one cycle per store)
//   mem_out                 RAM read data (RAM refreshes it on negedge)
// ---------------------------------------------------------------------------
module legv8_mem_controller #(
  parameter int unsigned MEMORY_WORDS = 6000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error,
  output logic [12:0] mem_address,
  output logic [63:0] mem_in,
  output logic        mem_write,
  input  logic [63:0] mem_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        live_q;
  logic [12:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic        accept;
  logic        fault;
  logic [12:0] req_word;

  assign req_word = req_addr[15:3];

`ifdef MEM_BOUNDS_CHECK_EN
  assign fault = (req_addr[2:0] != 3'd0)
              || (req_addr[63:16] != 48'd0)
              || (32'(req_word) >= MEMORY_WORDS);
`else
  // Without checking, the untranslated address bits and the RAM size are
  // deliberately ignored. Folding them into this sink keeps that explicit.
  logic unused_addr_bits;
  assign unused_addr_bits = (^{req_addr[63:16], req_addr[2:0]})
                          ^ (MEMORY_WORDS == 0);
  assign fault = 1'b0;
`endif

  // live_q keeps req_ready low during reset and for the partial cycle after
  // release. Ready then rises on the first clock edge.
  assign req_ready   = live_q && (state_q == IDLE);
  assign accept      = req_valid && req_ready;

  // These outputs are decoded straight from the state register. An
  // asynchronous reset therefore drops mem_write/rsp_valid immediately.
  assign mem_write   = (state_q == WRITE);
  assign rsp_valid   = (state_q == RESP);
  assign mem_address = addr_q;
  assign mem_in      = wdata_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_error   = error_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first. Otherwise a path
    // that skips an assignment would infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    error_d = error_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rdata_d = 64'd0;
          error_d = 1'b0;
          if (fault) begin
            // A faulting request never touches the RAM, so the address and
            // data registers (and therefore the RAM pins) keep their values.
            error_d = 1'b1;
            state_d = RESP;
          end else begin
            addr_d  = req_word;
            wdata_d = req_wdata;
            state_d = req_store ? WRITE : READ;
          end
        end
      end
      WRITE: state_d = RESP;
      READ: begin
        // mem_out was refreshed at the negedge inside this cycle. It is
        // captured at the edge that leaves READ.
        rdata_d = mem_out;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the edge, with no ordering races between blocks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the datapath registers are reset as well as the state. They
      // drive outputs that must read 0 during reset.
      state_q <= IDLE;
      live_q  <= 1'b0;
      addr_q  <= 13'd0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_legv8_mem_controller.sv
// ---------------------------------------------------------------------------
// tb_legv8_mem_controller
//
// Self-checking bench for legv8_mem_controller. It contains a behavioural
// model of the attached RAM, a directed vector table, hand-written throughput
// and reset sequences, and randomized accesses checked against a word-level
// reference model. The bench follows the MEM_BOUNDS_CHECK_EN build setting.
// ---------------------------------------------------------------------------
module tb_legv8_mem_controller;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_error;
  logic [12:0] mem_address;
  logic [63:0] mem_in;
  logic        mem_write;
  logic [63:0] mem_out = 64'd0;

  legv8_mem_controller #(.MEMORY_WORDS(6000)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_store   (req_store),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .mem_address (mem_address),
    .mem_in      (mem_in),
    .mem_write   (mem_write),
    .mem_out     (mem_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural data RAM. It writes on posedge and refreshes reads on negedge.
  logic [63:0] ram [0:8191] = '{default: 64'd0};
  always @(negedge clock) if (mem_write !== 1'b1) mem_out <= ram[mem_address];
  always @(posedge clock) if (mem_write === 1'b1) ram[mem_address] <= mem_in;

  int wr_pulses = 0;
  always @(posedge clock) if (mem_write === 1'b1) wr_pulses <= wr_pulses + 1;

  // Reference model: flat word array indexed by (byte address mod 64K) / 8.
  logic [63:0] model_mem [0:8191] = '{default: 64'd0};
  logic [12:0] model_last = 13'd0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic void model_access(input bit st, input logic [63:0] a, input logic [63:0] wd,
                                       output logic [63:0] rd, output logic er, output int lat,
                                       output int pulses, output logic [12:0] maddr);
    longint unsigned word;
    bit bad;
    word = (a % 65536) / 8;
    bad  = 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
    bad = (a % 8 != 0) || (a >= 64'd65536) || (word >= 6000);
`endif
    if (bad) begin
      rd = 64'd0; er = 1'b1; lat = 1; pulses = 0; maddr = model_last;
    end else begin
      er = 1'b0; lat = 2;
      model_last = 13'(word);
      if (st) begin
        model_mem[word] = wd; rd = 64'd0; pulses = 1;
      end else begin
        rd = model_mem[word]; pulses = 0;
      end
      maddr = model_last;
    end
  endfunction

  // Performs one access and returns what the DUT produced. rsp_ready is held
  // low for 'hold' extra cycles, and the response must stay stable meanwhile.
  task automatic access(input bit st, input logic [63:0] a, input logic [63:0] wd, input int hold,
                        output logic [63:0] rd, output logic er, output int lat,
                        output int pulses, output logic [12:0] maddr);
    int budget;
    int p0;
    rd = 'x; er = 'x; lat = -1; pulses = -1; maddr = 'x;
    @(negedge clock);
    req_valid = 1'b1; req_store = st; req_addr = a; req_wdata = wd; rsp_ready = 1'b0;
    budget = 0;
    while (req_ready !== 1'b1 && budget < 20) begin
      @(negedge clock);
      budget++;
    end
    if (req_ready !== 1'b1) begin
      check("accept_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    p0 = wr_pulses;
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 10) begin
      @(posedge clock);
      #1 lat++;
    end
    if (rsp_valid !== 1'b1) begin
      check("rsp_timeout", 64'(rsp_valid), 64'd1);
      return;
    end
    rd = rsp_rdata; er = rsp_error; maddr = mem_address;
    check("no_accept_in_resp", 64'(req_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_rdata", rsp_rdata, rd);
      check("hold_ready_low", 64'(req_ready), 64'd0);
    end
    @(negedge clock);
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 rsp_ready = 1'b0;
    check("rsp_consumed", 64'(rsp_valid), 64'd0);
    pulses = wr_pulses - p0;
  endtask

  typedef struct {
    bit          st;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          hold;
    logic [63:0] exp_rd;
    bit          exp_err;
    int          exp_lat;
    int          exp_pulses;
    logic [12:0] exp_maddr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [63:0] rd, m_rd, wd, a;
    logic        er, m_er;
    int          lat, m_lat, pulses, m_pulses, accepts, hold, kind;
    logic [12:0] maddr, m_maddr;
    bit          st;

    vecs.push_back('{1, 64'h10, 64'hDEADBEEF_CAFEF00D, 0, 64'd0, 0, 2, 1, 13'd2});
    vecs.push_back('{0, 64'h10, 64'd0, 0, 64'hDEADBEEF_CAFEF00D, 0, 2, 0, 13'd2});
    vecs.push_back('{0, 64'h10, 64'd0, 5, 64'hDEADBEEF_CAFEF00D, 0, 2, 0, 13'd2});
    vecs.push_back('{1, 64'h8, 64'h01234567_89ABCDEF, 0, 64'd0, 0, 2, 1, 13'd1});
    vecs.push_back('{1, 64'hBB78, 64'h5555AAAA_5555AAAA, 1, 64'd0, 0, 2, 1, 13'd5999});
    vecs.push_back('{0, 64'hBB78, 64'd0, 0, 64'h5555AAAA_5555AAAA, 0, 2, 0, 13'd5999});
`ifdef MEM_BOUNDS_CHECK_EN
    vecs.push_back('{0, 64'hC, 64'd0, 0, 64'd0, 1, 1, 0, 13'd5999});
    vecs.push_back('{1, 64'hBB80, 64'hFFFF0000_FFFF0000, 0, 64'd0, 1, 1, 0, 13'd5999});
    vecs.push_back('{0, 64'h1_0000_0010, 64'd0, 2, 64'd0, 1, 1, 0, 13'd5999});
    vecs.push_back('{0, 64'h10, 64'd0, 0, 64'hDEADBEEF_CAFEF00D, 0, 2, 0, 13'd2});
`else
    vecs.push_back('{0, 64'hC, 64'd0, 0, 64'h01234567_89ABCDEF, 0, 2, 0, 13'd1});
    vecs.push_back('{1, 64'hBB80, 64'hFFFF0000_FFFF0000, 0, 64'd0, 0, 2, 1, 13'd6000});
    vecs.push_back('{0, 64'hBB80, 64'd0, 0, 64'hFFFF0000_FFFF0000, 0, 2, 0, 13'd6000});
    vecs.push_back('{0, 64'h1_0000_0010, 64'd0, 2, 64'hDEADBEEF_CAFEF00D, 0, 2, 0, 13'd2});
`endif

    // Reset values.
    reset_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_addr = 64'd0;
    req_wdata = 64'd0; rsp_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_error", 64'(rsp_error), 64'd0);
    check("rst_mem_write", 64'(mem_write), 64'd0);
    check("rst_mem_address", 64'(mem_address), 64'd0);
    check("rst_mem_in", mem_in, 64'd0);
    #2 reset_n = 1'b1;
    #1 check("ready_before_edge", 64'(req_ready), 64'd0);
    @(posedge clock);
    #1 check("ready_after_edge", 64'(req_ready), 64'd1);

    // Directed vectors.
    foreach (vecs[i]) begin
      access(vecs[i].st, vecs[i].addr, vecs[i].wdata, vecs[i].hold, rd, er, lat, pulses, maddr);
      model_access(vecs[i].st, vecs[i].addr, vecs[i].wdata, m_rd, m_er, m_lat, m_pulses, m_maddr);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_error", i), 64'(er), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("vec%0d_write_pulses", i), 64'(pulses), 64'(vecs[i].exp_pulses));
      check($sformatf("vec%0d_mem_address", i), 64'(maddr), 64'(vecs[i].exp_maddr));
    end

    // Back-to-back loads with rsp_ready tied high: one accept every 3 cycles.
    @(negedge clock);
    rsp_ready = 1'b1; req_valid = 1'b1; req_store = 1'b0; req_addr = 64'h10;
    accepts = 0;
    for (int c = 0; c < 9; c++) begin
      if (req_ready === 1'b1) begin
        accepts++;
        model_access(1'b0, 64'h10, 64'd0, m_rd, m_er, m_lat, m_pulses, m_maddr);
      end
      @(negedge clock);
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    check("throughput_accepts_in_9", 64'(accepts), 64'd3);

    // Randomized accesses against the reference model.
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      st   = 1'($urandom_range(0, 1));
      wd   = {$urandom, $urandom};
      hold = $urandom_range(0, 2);
      case (kind)
        0:       a = 64'($urandom_range(0, 63)) * 8 + 64'($urandom_range(1, 7));
        1:       a = 64'($urandom_range(6000, 8191)) * 8;
        2:       a = (64'($urandom_range(1, 65535)) << 16) + 64'($urandom_range(0, 63)) * 8;
        3:       a = 64'($urandom_range(0, 5999)) * 8;
        default: a = 64'($urandom_range(0, 63)) * 8;
      endcase
      model_access(st, a, wd, m_rd, m_er, m_lat, m_pulses, m_maddr);
      access(st, a, wd, hold, rd, er, lat, pulses, maddr);
      check($sformatf("rnd%0d_rdata", i), rd, m_rd);
      check($sformatf("rnd%0d_error", i), 64'(er), 64'(m_er));
      check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(m_lat));
      check($sformatf("rnd%0d_write_pulses", i), 64'(pulses), 64'(m_pulses));
      check($sformatf("rnd%0d_mem_address", i), 64'(maddr), 64'(m_maddr));
    end

    // Reset asserted in the middle of a store abandons it.
    @(negedge clock);
    req_valid = 1'b1; req_store = 1'b1; req_addr = 64'h20; req_wdata = 64'hA5A5_0F0F_A5A5_0F0F;
    @(posedge clock);
    #1 req_valid = 1'b0;
    check("write_state_reached", 64'(mem_write), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_mem_write_drop", 64'(mem_write), 64'd0);
    check("async_rsp_valid", 64'(rsp_valid), 64'd0);
    check("async_req_ready", 64'(req_ready), 64'd0);
    check("async_mem_address", 64'(mem_address), 64'd0);
    model_last = 13'd0;
    @(posedge clock);
    #1 check("aborted_store_not_written", ram[4], model_mem[4]);
    @(negedge clock);
    #2 reset_n = 1'b1;
    #1 check("ready_low_before_edge", 64'(req_ready), 64'd0);
    @(posedge clock);
    #1 check("ready_one_edge_after_release", 64'(req_ready), 64'd1);
    check("no_response_after_abort", 64'(rsp_valid), 64'd0);
    access(1'b0, 64'h20, 64'd0, 0, rd, er, lat, pulses, maddr);
    model_access(1'b0, 64'h20, 64'd0, m_rd, m_er, m_lat, m_pulses, m_maddr);
    check("post_abort_load", rd, m_rd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
